snitch_regfile_wb: RTL

//  Write-back stage directly upstream of the integer register file's single write port.

---
 rtl/snitch_regfile_wb.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/snitch_regfile_wb.sv
// Write-back merge of ALU results and buffered load responses onto the regfile write port,
// with a pending-load scoreboard. Optional same-cycle load bypass: SNITCH_REGFILE_WB_BYPASS_EN.
module snitch_regfile_wb #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 5,
    parameter int unsigned FifoDepth   = 2,
    parameter int unsigned StarveLimit = 4,
    parameter int unsigned ZeroRegZero = 1,
    localparam int unsigned NumWords   = 2 ** AddrWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alu_valid_i,
    input  logic [AddrWidth-1:0] alu_waddr_i,
    input  logic [DataWidth-1:0] alu_wdata_i,
    output logic                 alu_ready_o,
    input  logic                 lsu_valid_i,
    input  logic [AddrWidth-1:0] lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_ready_o,
    input  logic                 ld_issue_i,
    input  logic [AddrWidth-1:0] ld_rd_i,
    output logic [NumWords-1:0]  pending_o,
    output logic [AddrWidth-1:0] waddr_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic                 we_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam int unsigned StW  = $clog2(StarveLimit + 1);

    typedef enum logic [1:0] {
        SrcIdle,
        SrcAlu,
        SrcFifo,
        SrcLsu
    } src_e;

    logic [AddrWidth-1:0] fifo_addr [FifoDepth];
    logic [DataWidth-1:0] fifo_data [FifoDepth];
    logic [PtrW-1:0]      rd_ptr;
    logic [PtrW-1:0]      wr_ptr;
    logic [CntW-1:0]      count;
    logic [StW-1:0]       starve_cnt;
    logic [NumWords-1:0]  pending;
    logic [NumWords-1:0]  pending_d;

    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 force_head;
    logic                 bypass;
    logic                 push;
    logic                 pop;
    src_e                 sel;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CntW'(FifoDepth));
    assign force_head = !fifo_empty && ((starve_cnt == StW'(StarveLimit)) || fifo_full);

`ifdef SNITCH_REGFILE_WB_BYPASS_EN
    assign bypass = fifo_empty && !alu_valid_i && lsu_valid_i;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        sel = SrcIdle;
        if (force_head) begin
            sel = SrcFifo;
        end else if (alu_valid_i) begin
            sel = SrcAlu;
        end else if (!fifo_empty) begin
            sel = SrcFifo;
        end else if (bypass) begin
            sel = SrcLsu;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        case (sel)
            SrcAlu: begin
                sel_addr = alu_waddr_i;
                sel_data = alu_wdata_i;
            end
            SrcFifo: begin
                sel_addr = fifo_addr[rd_ptr];
                sel_data = fifo_data[rd_ptr];
            end
            SrcLsu: begin
                sel_addr = lsu_waddr_i;
                sel_data = lsu_wdata_i;
            end
            default: begin
                sel_addr = '0;
                sel_data = '0;
            end
        endcase
    end

    // x0 writes still complete their handshake; only the enable is suppressed.
    assign waddr_o     = sel_addr;
    assign wdata_o     = sel_data;
    assign we_o        = rst_ni && (sel != SrcIdle) && !((ZeroRegZero != 0) && (sel_addr == '0));
    assign alu_ready_o = !force_head;
    assign lsu_ready_o = !fifo_full;

    assign pop  = (sel == SrcFifo);
    assign push = lsu_valid_i && lsu_ready_o && !bypass;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lsu_waddr_i;
            fifo_data[wr_ptr] <= lsu_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Counts how long a waiting load has been passed over by the ALU.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if ((sel == SrcAlu) && (starve_cnt != StW'(StarveLimit))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // A new issue overrides a write-back clearing the same register.
    always_comb begin
        pending_d = pending;
        if (pop || (sel == SrcLsu)) begin
            pending_d[sel_addr] = 1'b0;
        end
        if (ld_issue_i && !((ZeroRegZero != 0) && (ld_rd_i == '0))) begin
            pending_d[ld_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending <= '0;
        end else begin
            pending <= pending_d;
        end
    end

    assign pending_o = pending;

endmodule
